// File: rtl/risc_spm_pkg.sv
// Shared RISC_SPM definitions: serializer state encoding and default datapath width.
package risc_spm_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int RISC_SPM_WORD_SIZE = 8;

endpackage

// File: rtl/ser_bit_counter.sv
// Loadable down-counter for the word serializer; flags zero to mark the final bit.
module ser_bit_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] count_q, count_d;

  // Saturates at zero so a stray decrement can never wrap.
  always_comb begin
    count_d = count_q;
    if (load)                    count_d = load_val;
    else if (dec && count_q != '0) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/word_serializer.sv
// Parallel-in, MSB-first serial-out transmitter with valid/ready output handshake.
// Define SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module word_serializer
  import risc_spm_pkg::*;
#(
  parameter int WORD_SIZE = RISC_SPM_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic                 ready,
  output logic                 serial_out,
  output logic                 valid_out,
  input  logic                 out_ready,
  output logic                 last_out,
  output logic                 busy
);

`ifdef SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int SR_W = WORD_SIZE + PAR;
  localparam int CW   = $clog2(WORD_SIZE + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SR_W - 1);

  ser_state_t      state_q, state_d;
  logic [SR_W-1:0] shreg_q, shreg_d;
  logic [SR_W-1:0] frame_word;
  logic            cnt_load, xfer, cnt_zero;

  // Parity rides in the LSB so it leaves right after the last data bit.
`ifdef SERIALIZER_PARITY_EN
  assign frame_word = {data_in, ^data_in};
`else
  assign frame_word = data_in;
`endif

  assign cnt_load = (state_q == IDLE) && load;
  assign xfer     = (state_q == SHIFT) && out_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d = frame_word;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (out_ready) begin
          shreg_d = {shreg_q[SR_W-2:0], 1'b0};
          if (cnt_zero) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  ser_bit_counter #(.CW(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_INIT),
    .dec      (xfer),
    .zero     (cnt_zero)
  );

  assign valid_out  = (state_q == SHIFT);
  assign busy       = valid_out;
  assign ready      = ~valid_out;
  assign serial_out = valid_out & shreg_q[SR_W-1];
  assign last_out   = valid_out & cnt_zero;

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: directed plan items plus random traffic against a bit-queue model.
module tb_word_serializer;

  localparam int WS = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load = 1'b0;
  logic [WS-1:0] data_in = '0;
  logic          out_ready = 1'b0;
  logic          ready, serial_out, valid_out, last_out, busy;

  int n_chk  = 0;
  int n_fail = 0;
  int vcnt   = 0;

  // Model: bits still to send, in transmit order. Empty means idle.
  bit mq[$];

  always #5 clk = ~clk;

  word_serializer #(.WORD_SIZE(WS)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .ready      (ready),
    .serial_out (serial_out),
    .valid_out  (valid_out),
    .out_ready  (out_ready),
    .last_out   (last_out),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs on the falling edge, compare outputs to the model,
  // then advance the model by the rules of the rising edge.
  task automatic step(input logic r, input logic ld, input logic [WS-1:0] d, input logic ordy);
    bit idle;
    @(negedge clk);
    rst = r; load = ld; data_in = d; out_ready = ordy;
    idle = (mq.size() == 0);
    chk("ready",      ready,      idle);
    chk("busy",       busy,       !idle);
    chk("valid_out",  valid_out,  !idle);
    chk("serial_out", serial_out, idle ? 1'b0 : mq[0]);
    chk("last_out",   last_out,   mq.size() == 1);
    if (valid_out) vcnt++;
    @(posedge clk);
    if (!r) mq.delete();
    else if (idle && ld) begin
      for (int i = WS - 1; i >= 0; i--) mq.push_back(d[i]);
      if (PAR != 0) mq.push_back(^d);
    end else if (!idle && ordy) void'(mq.pop_front());
  endtask

  initial begin
    // 1: reset held two cycles, then idle
    rst = 1'b0;
    repeat (2) @(posedge clk);
    repeat (3) step(1, 0, '0, 1);

    // 2: basic frame, constant out_ready
    step(1, 1, 8'hA5, 1);
    repeat (WS + PAR + 1) step(1, 0, '0, 1);

    // 3: backpressure for 3 cycles after the first bit
    step(1, 1, 8'h81, 1);
    vcnt = 0;
    step(1, 0, '0, 0);
    repeat (2) step(1, 0, '0, 0);
    repeat (WS + PAR + 2) step(1, 0, '0, 1);
    chk("stall_frame_len", vcnt, WS + PAR + 3);

    // 4: load while busy is ignored
    step(1, 1, 8'hF0, 1);
    step(1, 0, '0, 1);
    step(1, 1, 8'h0F, 1);
    step(1, 1, 8'h0F, 0);
    repeat (WS + PAR + 2) step(1, 0, '0, 1);

    // 5: reset mid-frame, then a clean frame
    step(1, 1, 8'hFF, 1);
    repeat (3) step(1, 0, '0, 1);
    step(0, 1, 8'h55, 1);
    step(1, 1, 8'h01, 1);
    repeat (WS + PAR + 1) step(1, 0, '0, 1);

    // 6: parity frames (parity bit is only expected when the feature is built in)
    step(1, 1, 8'h07, 1);
    repeat (WS + PAR + 1) step(1, 0, '0, 1);
    step(1, 1, 8'h03, 1);
    repeat (WS + PAR + 1) step(1, 0, '0, 1);

    // Random traffic: loads, stalls, busy-loads and occasional resets
    for (int c = 0; c < 2000; c++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 2) == 0),
           WS'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Parallel-in, serial-out transmitter for the RISC_SPM datapath.
- Its counterpart is the single-bit load register: that block captures a bit under `load`; this block takes a full word under `load` and unloads it one bit per accepted cycle.
- Output side uses a valid/ready handshake.
- Sits between the register file/bus and a serial debug or peripheral link.

Parameters:
- WORD_SIZE, 8, data word width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- load  input  1  request to capture data_in; accepted only when ready=1.
- data_in  input  WORD_SIZE  word to transmit.
- ready  output  1  high when a new word can be loaded.
- serial_out  output  1  current bit; meaningful only while valid_out=1.
- valid_out  output  1  serial_out holds a valid bit.
- out_ready  input  1  downstream accepts the current bit.
- last_out  output  1  current bit is the final bit of the frame.
- busy  output  1  a frame is in progress (the inverse of ready).

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE; shift register and bit counter cleared.
  - ready=1; busy=0; valid_out=0; serial_out=0; last_out=0.
  - Reset takes priority over every other input and aborts any frame in progress. No partial-frame completion.
- States: IDLE, SHIFT.
- IDLE:
  - ready=1, valid_out=0.
  - load=1 at an edge: latch data_in into the shift register, set counter=WORD_SIZE-1, go to SHIFT.
  - Latency: the first bit is presented the cycle after load.
- SHIFT:
  - valid_out=1, ready=0.
  - serial_out = MSB of the shift register (MSB-first).
  - A bit transfers only on an edge where valid_out=1 and out_ready=1. On transfer, shift left by 1 and decrement the counter.
  - out_ready=0 holds serial_out, last_out and the counter unchanged; stalls of any length are legal.
  - last_out=1 exactly when counter=0.
  - Transfer with counter=0: go to IDLE. ready=1 on the next cycle; back-to-back frames therefore have one idle cycle between them.
- load while busy: ignored. The shift register is not disturbed and no error flag is raised.
- Simultaneous load and final transfer: load is ignored, because ready=0 on that cycle.
- Frame length: WORD_SIZE transfers, or WORD_SIZE+1 when the optional feature below is enabled.
- Counter width: $clog2(WORD_SIZE+1) bits. The counter never wraps; underflow is impossible by construction.
- All outputs are registered, or decoded from state/counter only. No combinational path from out_ready or load to any output.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - On load, capture the even-parity bit of data_in (XOR reduction) alongside the word.
  - After the WORD_SIZE data bits, present one extra bit (the parity bit) with valid_out=1.
  - last_out is asserted on the parity bit only, not on the final data bit.
  - The counter initialises to WORD_SIZE.
- Undefined: no parity logic; the frame is exactly WORD_SIZE bits.

Decomposition:
- Shared package risc_spm_pkg holds:
  - the state encoding typedef (ser_state_t: IDLE=1'b0, SHIFT=1'b1);
  - the default WORD_SIZE constant used across the RISC_SPM datapath.
- One natural sub-module: ser_bit_counter.
  - Loadable down-counter with a decrement enable.
  - Flags zero for last_out.
  - Uses the same clk/rst convention.

Test Plan:
1. Reset then idle: hold rst=0 for 2 cycles, release, no load -> ready=1, valid_out=0, serial_out=0, last_out=0 every cycle.
2. Basic frame, out_ready=1 constant: load 8'hA5 -> serial_out sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting the cycle after load; last_out only on the 8th bit; ready=1 the following cycle.
3. Backpressure: load 8'h81; deassert out_ready for 3 cycles after the first bit -> serial_out holds 1 and valid_out stays 1 for 3 extra cycles; the frame completes after 11 cycles total.
4. Load while busy: during the frame for 8'hF0, pulse load with data_in=8'h0F -> bits stay 1,1,1,1,0,0,0,0; 8'h0F is never transmitted.
5. Reset mid-frame: load 8'hFF, pull rst=0 after 3 bits -> next edge: valid_out=0, ready=1, serial_out=0; a subsequent load of 8'h01 transmits 0,0,0,0,0,0,0,1 cleanly.
6. SERIALIZER_PARITY_EN defined: load 8'h07 -> 8 data bits 0,0,0,0,0,1,1,1, then parity bit 1 with last_out=1; load 8'h03 -> parity bit 0.
